pulse_period_detector: RTL
==========================

# pulse_period_detector

Receive-side companion to the team's clock-divider FSMs. Samples a periodic pulse stream synchronous to `clk`, such as a divide-by-N output, and measures:
- its period in clock cycles;
- its high time in clock cycles.

It declares lock after a programmable number of identical consecutive periods, and flags loss of lock on mismatch or timeout. It sits in the clocking/test infrastructure to verify divider outputs in-system.

## Interface
Parameters:
- `CNT_W`, 8: width of the period and high-time counters. The maximum measurable period is 2^CNT_W − 1.
- `LOCK_COUNT`, 3: number of consecutive identical measurements required for lock. Must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `din`  in  1  pulse stream, synchronous to `clk`.
- `period`  out  CNT_W  last measured period in cycles (registered).
- `high_len`  out  CNT_W  high cycles within the last measured period (registered).
- `period_valid`  out  1  one-cycle pulse: `period`/`high_len` just updated.
- `locked`  out  1  level: lock criterion met.
- `err`  out  1  one-cycle pulse: lock lost through mismatch or timeout.
- `timeout`  out  1  one-cycle pulse: counter saturated with no rising edge.

## Operation
- **Edge detection:** `din_q` registers `din`. `rise = din & ~din_q` (combinational on current `din`). `din_q` resets to 0, so `din` high on the first cycle after reset counts as a rise.
- **Internal counters:**
  - `cnt` (CNT_W): set to 1 on a rise cycle, else increments, saturating at MAX = 2^CNT_W − 1.
  - `hcnt` (CNT_W): set to 1 on a rise cycle, else increments when `din`=1 and holds otherwise.
- **States:**
  - IDLE: wait for a rise. On a rise, load the counters and go to MEASURE. No measurement is made.
  - MEASURE: on a rise, take a measurement (below). Go to LOCKED when `match_cnt` reaches LOCK_COUNT.
  - LOCKED: same measurement on each rise. A mismatch gives `err`, clears `locked`, sets `match_cnt`=1, and goes to MEASURE.
  - Timeout, in MEASURE or LOCKED: `cnt`==MAX with no rise. Pulse `timeout` and go to IDLE. Clear `match_cnt` and `locked`. Also pulse `err` if the state was LOCKED.
- **Measurement (on rise, in MEASURE/LOCKED):**
  - `period`←`cnt`, `high_len`←`hcnt`, `period_valid` pulses.
  - Match: `cnt`==`period` and `hcnt`==`high_len`, compared against the previously stored values.
  - The first measurement after IDLE is never compared and sets `match_cnt`=1.
  - A match increments `match_cnt`, saturating at LOCK_COUNT.
  - A mismatch sets `match_cnt`=1.
- **Simultaneous rise and `cnt`==MAX:** the rise wins. Period MAX is a valid measurement, with no timeout.
- **Constant `din`:**
  - `din` stuck high: one rise, then timeout after MAX cycles, then IDLE.
  - `din` stuck low: same timeout, then IDLE.
- **Minimum period:** 2, with `din` toggling every cycle: period=2, high_len=1.
- `period`/`high_len` hold their values through timeout and IDLE. They change only on a measurement.

## Timing
- **Reset values:** `period`=0, `high_len`=0, `period_valid`=0, `locked`=0, `err`=0, `timeout`=0. Internally, `din_q`=0, `cnt`=0, `hcnt`=0, state=IDLE, `match_cnt`=0.
- **Measurement latency:** `period`, `high_len`, `period_valid` and `locked` update on the clock edge that ends the rise cycle, so they are visible one cycle after the rise.
- `period_valid`, `err` and `timeout` are high for exactly one cycle.
- **Lock latency:** rises at cycles r0, r1, … give `locked` visible the cycle after r_LOCK_COUNT. For a divide-by-3 stream with rises at 0, 3, 6, 9 and LOCK_COUNT=3, `locked`=1 from cycle 10.
- **Mismatch:** `err` and the `locked` drop appear together, one cycle after the offending rise, with the new `period` already presented.
- **Reset mid-operation:** all state and outputs clear immediately, asynchronously. The first sampled high `din` after reset release is treated as a rise.

## Test plan
- **Divide-by-3 stream** (1 high, 2 low), LOCK_COUNT=3 → `period`=3, `high_len`=1, `period_valid` every 3 cycles, `locked`=1 from cycle 10, no `err`.
- **Period change:** lock on period 4 (2 high/2 low), then switch to period 5 (2 high/3 low) → one `err` pulse and `locked`=0 at the first 5-cycle rise. Relock after 3 more identical periods.
- **Duty change only:** period 6, high 3 → high 2, same period → mismatch, `err` pulse, `high_len`=2.
- **Stuck low after lock:** CNT_W=4, so MAX=15 → `timeout` and `err` pulse 15 cycles after the last rise, `locked`=0, `period` holds.
- **Boundaries:** toggle every cycle → `period`=2, `high_len`=1. Period exactly 15 with CNT_W=4 → valid measurement, no `timeout`.
- **Async reset mid-lock:** assert `reset` between clock edges → all outputs 0 immediately. Relock requires the full LOCK_COUNT+1 rises.

Source files
------------

// File: rtl/pulse_period_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pulse_period_detector                                                 |
// | Measures period/high time of a clk-synchronous pulse stream and locks |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pulse_period_detector #(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_len,
   output logic             period_valid,
   output logic             locked,
   output logic             err,
   output logic             timeout
);

   localparam int               MC_W      = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
   localparam logic [MC_W-1:0]  c_LOCK    = MC_W'(LOCK_COUNT);
   localparam logic [MC_W-1:0]  c_MC_ONE  = MC_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_din_q;
   logic [CNT_W-1:0] r_cnt, r_hcnt, w_cnt_nxt, w_hcnt_nxt;
   logic [MC_W-1:0]  r_match_cnt, w_match_cnt_nxt;
   logic [CNT_W-1:0] r_period, r_high_len, w_period_nxt, w_high_len_nxt;
   logic             r_period_valid, r_locked, r_err, r_timeout;
   logic             w_period_valid_nxt, w_locked_nxt, w_err_nxt, w_timeout_nxt;
   logic             w_rise, w_match;

   always_comb begin
      w_rise = din & ~r_din_q;

      // Counters run in every state; only MEASURE/LOCKED interpret them.
      if (w_rise)
         w_cnt_nxt = c_CNT_ONE;
      else if (r_cnt == c_CNT_MAX)
         w_cnt_nxt = r_cnt;
      else
         w_cnt_nxt = r_cnt + c_CNT_ONE;

      if (w_rise)
         w_hcnt_nxt = c_CNT_ONE;
      else if (din && (r_hcnt != c_CNT_MAX))
         w_hcnt_nxt = r_hcnt + c_CNT_ONE;
      else
         w_hcnt_nxt = r_hcnt;

      w_match = (r_cnt == r_period) && (r_hcnt == r_high_len);
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_match_cnt_nxt    = r_match_cnt;
      w_period_nxt       = r_period;
      w_high_len_nxt     = r_high_len;
      w_period_valid_nxt = 1'b0;
      w_err_nxt          = 1'b0;
      w_timeout_nxt      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_rise)
               w_state_nxt = ST_MEASURE;
         end
         ST_MEASURE, ST_LOCKED: begin
            if (w_rise) begin
               w_period_nxt       = r_cnt;
               w_high_len_nxt     = r_hcnt;
               w_period_valid_nxt = 1'b1;
               // A zero match count marks the first measurement after IDLE.
               if (r_match_cnt == '0)
                  w_match_cnt_nxt = c_MC_ONE;
               else if (w_match)
                  w_match_cnt_nxt = (r_match_cnt == c_LOCK) ? c_LOCK : r_match_cnt + c_MC_ONE;
               else begin
                  w_match_cnt_nxt = c_MC_ONE;
                  w_err_nxt       = (r_state == ST_LOCKED);
               end
               w_state_nxt = (w_match_cnt_nxt == c_LOCK) ? ST_LOCKED : ST_MEASURE;
            end else if (r_cnt == c_CNT_MAX) begin
               w_timeout_nxt   = 1'b1;
               w_err_nxt       = (r_state == ST_LOCKED);
               w_match_cnt_nxt = '0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_locked_nxt = (w_state_nxt == ST_LOCKED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_din_q        <= 1'b0;
         r_cnt          <= '0;
         r_hcnt         <= '0;
         r_match_cnt    <= '0;
         r_period       <= '0;
         r_high_len     <= '0;
         r_period_valid <= 1'b0;
         r_locked       <= 1'b0;
         r_err          <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_din_q        <= din;
         r_cnt          <= w_cnt_nxt;
         r_hcnt         <= w_hcnt_nxt;
         r_match_cnt    <= w_match_cnt_nxt;
         r_period       <= w_period_nxt;
         r_high_len     <= w_high_len_nxt;
         r_period_valid <= w_period_valid_nxt;
         r_locked       <= w_locked_nxt;
         r_err          <= w_err_nxt;
         r_timeout      <= w_timeout_nxt;
      end
   end

   assign period       = r_period;
   assign high_len     = r_high_len;
   assign period_valid = r_period_valid;
   assign locked       = r_locked;
   assign err          = r_err;
   assign timeout      = r_timeout;

endmodule
`default_nettype wire
